csr_host_seq: RTL
=================

CSR_HOST_SEQ -- requirements
Module: csr_host_seq

Interface
REQ-001 SHALL have parameter CSR_WIDTH, default 32, CSR data width.
REQ-002 SHALL have parameter CSR_ADDR_WIDTH, default 32, CSR address width.
REQ-003 SHALL have parameter POLL_TIMEOUT, default 1024, maximum STATUS reads per poll before error.
REQ-004 SHALL have ports, in this order:
  - clk_i  in  1  sole clock, rising edge.
  - rst_i  in  1  reset, asynchronous, active-high.
  - start_i  in  1  pulse that starts one job.
  - busy_o  out  1  high in every state except IDLE.
  - error_o  out  1  sticky poll-timeout flag.
  - cfg_binding_i, cfg_bundling_i, cfg_am_base_i, cfg_am_max_i  in  CSR_WIDTH each  data for CSR addresses 3, 4, 5 and 6.
  - sample_valid_i  in  1  sample offered.
  - sample_ready_o  out  1  sample accepted when valid and ready are both high.
  - sample_value_i  in  6  sample value.
  - sample_shift_i  in  6  shift amount.
  - sample_last_i  in  1  marks the final sample.
  - result_o  out  5  captured STATUS[7:3].
  - result_valid_o  out  1  one-cycle result pulse.
  - csr_addr_o  out  CSR_ADDR_WIDTH  CSR address.
  - csr_wr_data_o  out  CSR_WIDTH  CSR write data.
  - csr_wr_en_o  out  1  1 = write, 0 = read.
  - csr_req_valid_o  out  1  request valid.
  - csr_req_ready_i  in  1  responder ready; mirrors the accelerator's in_ready.
  - csr_rd_data_i  in  CSR_WIDTH  read data, valid in the response cycle.
  - csr_rsp_valid_i  in  1  response valid; same cycle as the request.
  - csr_rsp_ready_o  out  1  response ready.

Function
REQ-005 SHALL keep at most one CSR transaction outstanding and hold addr, wr_data and wr_en stable while csr_req_valid_o=1.
REQ-006 SHALL complete a transaction in the cycle where csr_req_valid_o=1 and csr_rsp_valid_i=1; a write to address 1 with bit0=1 SHALL also require csr_req_ready_i=1; csr_rsp_ready_o SHALL equal csr_req_valid_o.
REQ-007 SHALL implement these FSM states: IDLE, WR_RST, WR_BIND, WR_BUND, WR_BASE, WR_MAX, WR_START, WAIT_SAMPLE, POLL_RDY, WR_IN, WR_IN_CLR, WR_DONE, POLL_OUT.
REQ-008 SHALL leave IDLE for WR_RST on start_i=1 and SHALL ignore start_i in every other state.
REQ-009 SHALL perform these write transactions, each advancing to the next state on completion:
  - WR_RST: address 7, data 1.
  - WR_BIND: address 3, data cfg_binding_i.
  - WR_BUND: address 4, data cfg_bundling_i.
  - WR_BASE: address 5, data cfg_am_base_i.
  - WR_MAX: address 6, data cfg_am_max_i.
  - WR_START: address 0, data 1; then go to WAIT_SAMPLE.
REQ-010 SHALL register all cfg_* inputs on start_i acceptance so that later cfg changes do not affect the running job.
REQ-011 SHALL assert sample_ready_o only in WAIT_SAMPLE with no CSR request active, capture value, shift and last on handshake, then enter POLL_RDY.
REQ-012 SHALL, in POLL_RDY and POLL_OUT, repeatedly read address 2 with at least one idle cycle between reads.
REQ-013 SHALL leave POLL_RDY for WR_IN when a completed read returns bit1=1.
REQ-014 SHALL leave POLL_OUT when a completed read returns bit2=1.
REQ-015 SHALL, in WR_IN, write address 1 with data {18'b0, 1'b0, shift[5:0], value[5:0], 1'b1}.
REQ-016 SHALL, in WR_IN_CLR, write address 1 with the same data but bit0=0, then go to WR_DONE if last, else to WAIT_SAMPLE.
REQ-017 SHALL, in WR_DONE, write address 1 with bit13=1, bit0=0, the same value and shift, then go to POLL_OUT.
REQ-018 SHALL, when POLL_OUT sees bit2=1, load result_o from rd_data[7:3] and pulse result_valid_o high for exactly one cycle on entering IDLE.
REQ-019 SHALL hold result_o until the next result.
REQ-020 SHALL keep a poll counter that clears on entry to a poll state and increments per completed read; reaching POLL_TIMEOUT without the awaited bit SHALL set error_o, drop csr_req_valid_o and return to IDLE.
REQ-021 SHALL hold error_o until the next accepted start_i, which clears it.
REQ-022 SHALL apply the awaited bit when a poll read with the awaited bit set completes in the same cycle the counter hits POLL_TIMEOUT; no error is raised.
REQ-023 SHALL allow a sample to be held pending indefinitely with no timeout in WAIT_SAMPLE.

Reset
REQ-024 SHALL, while rst_i=1, asynchronously force state=IDLE, every output and internal register to 0, result_o=0 and error_o=0.
REQ-025 SHALL, when reset is applied mid-transaction, drop csr_req_valid_o immediately and resume no transaction after release.

Verification
REQ-026 SHALL be covered by these directed scenarios:
  - Full job: start_i, 3 samples (values 5,9,63; shift 2; last on the 3rd), responder with in_ready=1 and out=17. Required: writes to addresses 7,3,4,5,6,0 in order, then per sample a status read, input write with bit0=1, then with bit0=0; done write bit13=1; result_o=17 with result_valid_o pulsed for 1 cycle.
  - in_ready held 0 for 20 cycles: the input write with bit0=1 is never issued; polls are spaced; once ready=1 the write issues.
  - POLL_TIMEOUT=8 with output_valid never set: exactly 8 STATUS reads, then error_o=1, busy_o=0; the next start_i clears error_o.
  - start_i pulsed during WR_BUND and during POLL_OUT: no effect on the sequence.
  - rst_i asserted mid WR_IN with req_valid=1: outputs 0 in the same cycle; after release busy_o=0 and no CSR request until start_i.
  - cfg_binding_i changed after start_i: address 3 is written with the value captured at start_i.

Source files
------------

// File: rtl/csr_host_seq.sv
// Host-side sequencer that programs an accelerator over a single-outstanding CSR port,
// streams samples into it, polls STATUS, and captures the final result.
module csr_host_seq #(
    parameter int CSR_WIDTH      = 32,
    parameter int CSR_ADDR_WIDTH = 32,
    parameter int POLL_TIMEOUT   = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      error_o,
    input  logic [CSR_WIDTH-1:0]      cfg_binding_i,
    input  logic [CSR_WIDTH-1:0]      cfg_bundling_i,
    input  logic [CSR_WIDTH-1:0]      cfg_am_base_i,
    input  logic [CSR_WIDTH-1:0]      cfg_am_max_i,
    input  logic                      sample_valid_i,
    output logic                      sample_ready_o,
    input  logic [5:0]                sample_value_i,
    input  logic [5:0]                sample_shift_i,
    input  logic                      sample_last_i,
    output logic [4:0]                result_o,
    output logic                      result_valid_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
    output logic [CSR_WIDTH-1:0]      csr_wr_data_o,
    output logic                      csr_wr_en_o,
    output logic                      csr_req_valid_o,
    input  logic                      csr_req_ready_i,
    input  logic [CSR_WIDTH-1:0]      csr_rd_data_i,
    input  logic                      csr_rsp_valid_i,
    output logic                      csr_rsp_ready_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_RST, S_WR_BIND, S_WR_BUND, S_WR_BASE, S_WR_MAX, S_WR_START,
        S_WAIT_SAMPLE, S_POLL_RDY, S_WR_IN, S_WR_IN_CLR, S_WR_DONE, S_POLL_OUT
    } state_t;

    localparam int                LP_CW       = $clog2(POLL_TIMEOUT + 1);
    localparam logic [LP_CW-1:0]  LP_CNT_LAST = LP_CW'(POLL_TIMEOUT - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CSR_WIDTH-1:0]  r_cfg_bind, r_cfg_bund, r_cfg_base, r_cfg_max;
    logic [5:0]            r_value, r_shift;
    logic                  r_last;
    logic                  r_gap;
    logic [LP_CW-1:0]      r_poll_cnt;
    logic                  r_error;
    logic [4:0]            r_result;
    logic                  r_result_valid;

    logic                      w_req_valid, w_wr_en, w_done;
    logic                      w_poll, w_poll_hit, w_poll_fail, w_accept, w_sample_hs;
    logic [CSR_ADDR_WIDTH-1:0] w_addr;
    logic [CSR_WIDTH-1:0]      w_wr_data;
    logic [31:0]               w_in_word, w_in_clr_word, w_done_word;

    assign w_in_word     = {18'b0, 1'b0, r_shift, r_value, 1'b1};
    assign w_in_clr_word = {18'b0, 1'b0, r_shift, r_value, 1'b0};
    assign w_done_word   = {18'b0, 1'b1, r_shift, r_value, 1'b0};

    // The input-strobe write additionally waits for the accelerator's in_ready.
    assign w_done      = w_req_valid && csr_rsp_valid_i && (r_state != S_WR_IN || csr_req_ready_i);
    assign w_poll      = (r_state == S_POLL_RDY) || (r_state == S_POLL_OUT);
    assign w_poll_hit  = (r_state == S_POLL_RDY && csr_rd_data_i[1]) ||
                         (r_state == S_POLL_OUT && csr_rd_data_i[2]);
    assign w_poll_fail = w_poll && w_done && !w_poll_hit && (r_poll_cnt == LP_CNT_LAST);
    assign w_accept    = (r_state == S_IDLE) && start_i;
    assign w_sample_hs = sample_valid_i && sample_ready_o;

    always_comb begin
        w_req_valid = 1'b0;
        w_wr_en     = 1'b0;
        w_addr      = '0;
        w_wr_data   = '0;
        case (r_state)
            S_WR_RST:    begin w_req_valid = 1'b1; w_wr_en = 1'b1; w_addr = CSR_ADDR_WIDTH'(7); w_wr_data = CSR_WIDTH'(1); end
            S_WR_BIND:   begin w_req_valid = 1'b1; w_wr_en = 1'b1; w_addr = CSR_ADDR_WIDTH'(3); w_wr_data = r_cfg_bind; end
            S_WR_BUND:   begin w_req_valid = 1'b1; w_wr_en = 1'b1; w_addr = CSR_ADDR_WIDTH'(4); w_wr_data = r_cfg_bund; end
            S_WR_BASE:   begin w_req_valid = 1'b1; w_wr_en = 1'b1; w_addr = CSR_ADDR_WIDTH'(5); w_wr_data = r_cfg_base; end
            S_WR_MAX:    begin w_req_valid = 1'b1; w_wr_en = 1'b1; w_addr = CSR_ADDR_WIDTH'(6); w_wr_data = r_cfg_max; end
            S_WR_START:  begin w_req_valid = 1'b1; w_wr_en = 1'b1; w_addr = CSR_ADDR_WIDTH'(0); w_wr_data = CSR_WIDTH'(1); end
            S_WR_IN:     begin w_req_valid = 1'b1; w_wr_en = 1'b1; w_addr = CSR_ADDR_WIDTH'(1); w_wr_data = CSR_WIDTH'(w_in_word); end
            S_WR_IN_CLR: begin w_req_valid = 1'b1; w_wr_en = 1'b1; w_addr = CSR_ADDR_WIDTH'(1); w_wr_data = CSR_WIDTH'(w_in_clr_word); end
            S_WR_DONE:   begin w_req_valid = 1'b1; w_wr_en = 1'b1; w_addr = CSR_ADDR_WIDTH'(1); w_wr_data = CSR_WIDTH'(w_done_word); end
            S_POLL_RDY, S_POLL_OUT: begin w_req_valid = !r_gap; w_addr = CSR_ADDR_WIDTH'(2); end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:        if (start_i) w_state_nxt = S_WR_RST;
            S_WR_RST:      if (w_done) w_state_nxt = S_WR_BIND;
            S_WR_BIND:     if (w_done) w_state_nxt = S_WR_BUND;
            S_WR_BUND:     if (w_done) w_state_nxt = S_WR_BASE;
            S_WR_BASE:     if (w_done) w_state_nxt = S_WR_MAX;
            S_WR_MAX:      if (w_done) w_state_nxt = S_WR_START;
            S_WR_START:    if (w_done) w_state_nxt = S_WAIT_SAMPLE;
            S_WAIT_SAMPLE: if (w_sample_hs) w_state_nxt = S_POLL_RDY;
            S_POLL_RDY: begin
                if (w_done && w_poll_hit) w_state_nxt = S_WR_IN;
                else if (w_poll_fail)     w_state_nxt = S_IDLE;
            end
            S_WR_IN:       if (w_done) w_state_nxt = S_WR_IN_CLR;
            S_WR_IN_CLR:   if (w_done) w_state_nxt = r_last ? S_WR_DONE : S_WAIT_SAMPLE;
            S_WR_DONE:     if (w_done) w_state_nxt = S_POLL_OUT;
            S_POLL_OUT:    if ((w_done && w_poll_hit) || w_poll_fail) w_state_nxt = S_IDLE;
            default:       w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cfg_bind     <= '0;
            r_cfg_bund     <= '0;
            r_cfg_base     <= '0;
            r_cfg_max      <= '0;
            r_value        <= '0;
            r_shift        <= '0;
            r_last         <= 1'b0;
            r_gap          <= 1'b0;
            r_poll_cnt     <= '0;
            r_error        <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cfg_bind <= cfg_binding_i;
                r_cfg_bund <= cfg_bundling_i;
                r_cfg_base <= cfg_am_base_i;
                r_cfg_max  <= cfg_am_max_i;
            end
            if (w_sample_hs) begin
                r_value <= sample_value_i;
                r_shift <= sample_shift_i;
                r_last  <= sample_last_i;
            end
            // A completed read forces one idle cycle before the next poll.
            r_gap <= w_poll && w_done;
            if (w_state_nxt != r_state)  r_poll_cnt <= '0;
            else if (w_poll && w_done)   r_poll_cnt <= r_poll_cnt + LP_CW'(1);
            if (w_accept)          r_error <= 1'b0;
            else if (w_poll_fail)  r_error <= 1'b1;
            r_result_valid <= (r_state == S_POLL_OUT) && w_done && w_poll_hit;
            if ((r_state == S_POLL_OUT) && w_done && w_poll_hit) r_result <= csr_rd_data_i[7:3];
        end
    end

    assign busy_o          = (r_state != S_IDLE);
    assign error_o         = r_error;
    assign sample_ready_o  = (r_state == S_WAIT_SAMPLE) && !w_req_valid;
    assign result_o        = r_result;
    assign result_valid_o  = r_result_valid;
    assign csr_addr_o      = w_addr;
    assign csr_wr_data_o   = w_wr_data;
    assign csr_wr_en_o     = w_wr_en;
    assign csr_req_valid_o = w_req_valid;
    assign csr_rsp_ready_o = w_req_valid;

endmodule
